wb_uart_tx: RTL and testbench
=============================

// Module: wb_uart_tx
// PURPOSE
//  Wishbone pipelined responder: a UART transmitter the CPU drives through memory-mapped writes.
//  Sits beside mem on the CPU data bus and answers the same stb/ack/stall handshake mem does.
//  Buffers bytes in a FIFO, serialises 8N1 frames on o_tx, stalls the initiator when the FIFO is full.
// PARAMETERS
//  FIFO_DEPTH   8    TX FIFO entries; power of 2, >=2
//  DEFAULT_DIV  15   reset value of DIVISOR; clocks per bit = DIV+1
// PORTS
//  i_clk       in   1   clock; all logic on rising edge
//  i_reset     in   1   synchronous, active-high reset
//  i_wb_stb    in   1   request strobe
//  i_wb_we     in   1   1=write, 0=read
//  i_wb_addr   in   32  byte address; only [3:2] decoded
//  i_wb_data   in   32  write data
//  i_wb_sel    in   3   access size from CPU; ignored, all accesses treated as word
//  o_wb_data   out  32  read data, valid with o_wb_ack, else 0
//  o_wb_ack    out  1   one-cycle acknowledge
//  o_wb_stall  out  1   request not accepted this cycle
//  o_tx        out  1   serial line, idle high
// BEHAVIOUR
//  Reset: o_tx=1, o_wb_ack=0, o_wb_data=0, FIFO empty, state IDLE, DIVISOR=DEFAULT_DIV, baud counter 0.
//  Register map, addr[3:2]:
//   0 DATA    W: push data[7:0] into FIFO. R: returns 0.
//   1 STATUS  R: [0]=fifo full, [1]=fifo empty, [2]=busy (state!=IDLE), [15:8]=fifo count. W ignored.
//   2 DIVISOR R/W: [15:0]; W takes effect at next frame start (latched on IDLE->START).
//   3 -       R returns 0, W ignored; still acked.
//  Handshake:
//   - accepted = i_wb_stb & ~o_wb_stall; o_wb_ack=1 exactly the cycle after each accept.
//   - back-to-back accepts allowed: one ack per accepted request, in order, no gaps added.
//   - o_wb_stall = i_wb_stb & i_wb_we & (addr[3:2]==0) & fifo_full; combinational.
//   - full FIFO with same-cycle pop still stalls (push retried next cycle).
//   - STATUS read reflects state before the same-cycle push/pop.
//  FIFO: read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
//   - push+pop same cycle when not full: count unchanged, both pointers advance.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: o_tx=1; FIFO not empty -> pop byte into shift reg, latch divisor, go START.
//   - START: o_tx=0 for DIV+1 cycles.
//   - DATA: 8 bits LSB first, DIV+1 cycles each; bit index 0..7.
//   - STOP: o_tx=1 for DIV+1 cycles; then IDLE, or directly START if FIFO not empty (no idle gap).
//   - Baud counter counts 0..DIV; bit boundary when counter==DIV.
//   - DIV=0: one clock per bit, legal.
//  Reset mid-frame: o_tx=1 next cycle, frame abandoned, FIFO contents discarded, pending ack dropped.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state inserted between DATA and STOP.
//   - transmits even parity (XOR of 8 data bits) for DIV+1 cycles.
//   - STATUS[3] reads 1.
//  UART_TX_PARITY_EN undefined:
//   - no PARITY state, frame is 8N1.
//   - STATUS[3] reads 0.
// TESTING
//  1 Reset, then read STATUS -> ack next cycle, data=0x00000002 (empty, idle); o_tx=1 throughout.
//  2 DIV=3, write DATA=0x55 -> o_tx: start 0 for 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then stop 1 for 4 clk.
//  3 Write 9 bytes back-to-back, FIFO_DEPTH=8, DIV=15:
//    - 1st popped immediately, so 9th accepted without stall.
//    - 10th stalls until first frame ends; ack count == accept count.
//  4 Two queued bytes 0xA5,0x3C -> second start bit begins the cycle after the first stop bit ends.
//  5 Write DIVISOR=1 mid-frame at DIV=7 -> current frame keeps 8 clk/bit; next frame uses 2 clk/bit.
//  6 Assert i_reset during DATA bit 3 -> o_tx=1 next cycle, STATUS=empty, no further frame.
//    With UART_TX_PARITY_EN, DATA=0x07 -> parity bit 1 before stop.

Source files
------------

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone pipelined responder that queues bytes in a TX FIFO and sends them as UART
// frames on o_tx. Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module wb_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [2:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_tx
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic ParityEn = 1'b1;
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    localparam logic ParityEn = 1'b0;
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      byte_q, byte_d;
    logic [15:0]     cur_div_q, cur_div_d;
    logic [15:0]     div_q, div_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic fifo_full, fifo_empty, accept, push, pop, load, bit_end;
    logic unused_bits;

    assign unused_bits = ^{i_wb_sel, i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data[31:16]};

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign o_wb_stall = i_wb_stb & i_wb_we & (i_wb_addr[3:2] == 2'd0) & fifo_full;
    assign accept     = i_wb_stb & ~o_wb_stall;
    assign push       = accept & i_wb_we & (i_wb_addr[3:2] == 2'd0);
    assign bit_end    = (baud_q == cur_div_q);
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;

    // Register access; STATUS samples pre-update FIFO/FSM state.
    always_comb begin
        ack_d   = accept;
        rdata_d = '0;
        div_d   = div_q;
        if (accept) begin
            case (i_wb_addr[3:2])
                2'd1: if (!i_wb_we) rdata_d = {16'd0, 8'(count_q), 4'd0, ParityEn,
                                               state_q != StIdle, fifo_empty, fifo_full};
                2'd2: if (i_wb_we) div_d = i_wb_data[15:0];
                      else rdata_d = {16'd0, div_q};
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        cur_div_d = cur_div_q;
        load      = 1'b0;
        case (state_q)
            StIdle:  load = !fifo_empty;
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else baud_d = baud_q + 16'd1;
            end
            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else bit_d = bit_q + 3'd1;
                end else baud_d = baud_q + 16'd1;
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else baud_d = baud_q + 16'd1;
            end
`endif
            StStop: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                    load    = !fifo_empty;
                end else baud_d = baud_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase
        // Frame start: pop a byte and freeze the divisor for the whole frame.
        pop = load;
        if (load) begin
            byte_d    = fifo_mem[rd_ptr_q];
            cur_div_d = div_q;
            baud_d    = '0;
            state_d   = StStart;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        case (state_q)
            StStart:  o_tx = 1'b0;
            StData:   o_tx = byte_q[bit_q];
`ifdef UART_TX_PARITY_EN
            StParity: o_tx = ^byte_q;
`endif
            default:  o_tx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            cur_div_q <= 16'(DEFAULT_DIV);
            div_q     <= 16'(DEFAULT_DIV);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            cur_div_q <= cur_div_d;
            div_q     <= div_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= i_wb_data[7:0];
    end
endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: register vectors, directed waveform sequences and a randomized phase checked by
// a frame-level line model. Honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_wb_uart_tx;
    localparam int unsigned Depth = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBits = 11;
    localparam logic [31:0] ParBit = 32'h8;
`else
    localparam int NBits = 10;
    localparam logic [31:0] ParBit = 32'h0;
`endif
    localparam logic [31:0] StatEmpty = 32'h2 | ParBit;

    logic        clk = 1'b0;
    logic        reset, stb, we, ack, stall, tx;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  sel;

    always #5 clk = ~clk;

    wb_uart_tx #(.FIFO_DEPTH(Depth), .DEFAULT_DIV(15)) dut (
        .i_clk(clk), .i_reset(reset), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_data(rdata), .o_wb_ack(ack),
        .o_wb_stall(stall), .o_tx(tx)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h", name, act, exp);
    endtask

    // Line level of frame bit k: start, 8 data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line model: bytes accepted into DATA, in order; each observed frame must match one exactly.
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    bit         mon_busy = 1'b0;
    int         mon_div = 15;
    int         mon_cyc, mon_err;
    logic [7:0] mon_byte;

    initial forever begin
        @(negedge clk);
        if (!mon_en) mon_busy = 1'b0;
        else if (!mon_busy) begin
            if (tx === 1'b0) begin
                check("mon_start_expected", 32'(exp_q.size() != 0), 32'd1);
                mon_byte = 8'h00;
                if (exp_q.size() != 0) mon_byte = exp_q.pop_front();
                mon_busy = 1'b1;
                mon_cyc  = 1;
                mon_err  = 0;
            end
        end else begin
            if (tx !== frame_bit(mon_byte, mon_cyc / (mon_div + 1))) mon_err++;
            mon_cyc++;
            if (mon_cyc == NBits * (mon_div + 1)) begin
                check($sformatf("mon_frame_%02h", mon_byte), 32'(mon_err), 32'd0);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        int waits = 0;
        @(negedge clk);
        stb = 1'b1; we = w; addr = a; wdata = d; sel = 3'($urandom);
        while (stall && waits < 5000) begin
            @(negedge clk);
            waits++;
        end
        check("stall_timeout", 32'(stall), 32'd0);
        if (mon_en && w && a[3:2] == 2'd0) exp_q.push_back(d[7:0]);
        @(negedge clk);
        check("ack", 32'(ack), 32'd1);
        rd  = rdata;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    logic cap_q[$];
    logic exp_bits[$];

    task automatic wait_fall(output bit ok);
        int w = 0;
        while (tx !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        ok = (tx === 1'b0);
    endtask

    task automatic capture(input string name, input int n);
        bit ok;
        cap_q.delete();
        wait_fall(ok);
        check({name, "_start_seen"}, 32'(ok), 32'd1);
        for (int i = 0; i < n; i++) begin
            cap_q.push_back(tx);
            @(negedge clk);
        end
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        for (int k = 0; k < NBits; k++)
            for (int c = 0; c <= div; c++) exp_bits.push_back(frame_bit(b, k));
    endtask

    task automatic cmp_stream(input string name);
        int errs = 0;
        for (int i = 0; i < exp_bits.size(); i++)
            if (i >= cap_q.size() || cap_q[i] !== exp_bits[i]) errs++;
        check(name, 32'(errs), 32'd0);
        exp_bits.delete();
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp_q.size() != 0 || mon_busy) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        vec_t        vecs[9];
        bit          ok;
        int          n_acc, n_ack, first_stall, stall_cyc, lows, div;
        logic        st;

        reset = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Status read straight out of reset.
        wb_xfer(1'b0, 32'h4, 32'h0, rd);
        check("t1_status", rd, StatEmpty);
        check("t1_tx_idle", 32'(tx), 32'd1);

        vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, StatEmpty, "status_empty"};
        vecs[1] = '{1'b1, 32'h0000_0008, 32'hABCD_0003, 1'b0, 32'h0,     "div_write"};
        vecs[2] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         1'b1, 32'h3,     "div_read_hi_addr"};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0,     "data_read_zero"};
        vecs[4] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 1'b0, 32'h0,     "rsvd_write"};
        vecs[5] = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h0,     "rsvd_read_zero"};
        vecs[6] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 32'h0,     "status_write"};
        vecs[7] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, StatEmpty, "status_wr_ignored"};
        vecs[8] = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h3,     "div_readback"};
        for (int i = 0; i < 9; i++) begin
            wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
        end
        @(negedge clk);
        check("rdata_zero_without_ack", rdata, 32'd0);

        // Single 0x55 frame at DIV=3.
        wb_xfer(1'b1, 32'h0, 32'h55, rd);
        capture("t2", NBits * 4 + 4);
        add_frame(8'h55, 3);
        for (int i = 0; i < 4; i++) exp_bits.push_back(1'b1);
        cmp_stream("t2_wave_55");

        // Two queued bytes: second start bit follows the first stop bit with no gap.
        wb_xfer(1'b1, 32'h0, 32'hA5, rd);
        fork
            capture("t4", 2 * NBits * 4 + 4);
            wb_xfer(1'b1, 32'h0, 32'h3C, rd);
        join
        add_frame(8'hA5, 3);
        add_frame(8'h3C, 3);
        for (int i = 0; i < 4; i++) exp_bits.push_back(1'b1);
        cmp_stream("t4_back_to_back");

        // Divisor change mid-frame applies only to the next frame.
        wb_xfer(1'b1, 32'h8, 32'h7, rd);
        wb_xfer(1'b1, 32'h0, 32'h5A, rd);
        fork
            capture("t5", NBits * 8 + NBits * 2 + 4);
            begin
                repeat (20) @(negedge clk);
                wb_xfer(1'b1, 32'h8, 32'h1, rd);
                wb_xfer(1'b1, 32'h0, 32'hC3, rd);
            end
        join
        add_frame(8'h5A, 7);
        add_frame(8'hC3, 1);
        for (int i = 0; i < 4; i++) exp_bits.push_back(1'b1);
        cmp_stream("t5_div_change");
        wb_xfer(1'b0, 32'h8, 32'h0, rd);
        check("t5_div_read", rd, 32'h1);

        // Reset during data bit 3 with another byte queued and a read in flight.
        wb_xfer(1'b1, 32'h8, 32'h3, rd);
        wb_xfer(1'b1, 32'h0, 32'h07, rd);
        wait_fall(ok);
        check("t6_start_seen", 32'(ok), 32'd1);
        wb_xfer(1'b1, 32'h0, 32'hF0, rd);
        repeat (15) @(negedge clk);
        check("t6_in_bit3", 32'(tx), 32'd0);
        reset = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h4;
        @(negedge clk);
        check("t6_tx_high", 32'(tx), 32'd1);
        check("t6_ack_dropped", 32'(ack), 32'd0);
        check("t6_rdata_zero", rdata, 32'd0);
        reset = 1'b0; stb = 1'b0;
        wb_xfer(1'b0, 32'h4, 32'h0, rd);
        check("t6_status_empty", rd, StatEmpty);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t6_no_frame", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
        wb_xfer(1'b1, 32'h8, 32'h3, rd);
        wb_xfer(1'b1, 32'h0, 32'h07, rd);
        capture("tp", NBits * 4);
        check("tp_parity_bit", 32'(cap_q[9 * 4 + 1]), 32'd1);
        add_frame(8'h07, 3);
        cmp_stream("tp_wave_07");
`endif

        // Nine back-to-back writes fit (first is popped at once); the tenth stalls.
        wb_xfer(1'b1, 32'h8, 32'd15, rd);
        mon_en = 1'b1; mon_div = 15;
        n_acc = 0; n_ack = 0; first_stall = -1; stall_cyc = 0;
        @(negedge clk);
        stb = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hC0;
        for (int cyc = 0; cyc < 1000 && n_acc < 10; cyc++) begin
            st = stall;
            if (st) begin
                stall_cyc++;
                if (first_stall < 0) first_stall = n_acc;
            end else exp_q.push_back(wdata[7:0]);
            @(negedge clk);
            n_ack += int'(ack);
            if (!st) begin
                n_acc++;
                wdata = 32'hC0 + 32'(n_acc);
            end
            if (n_acc == 10) stb = 1'b0;
        end
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("t3_no_extra_ack", 32'(ack), 32'd0);
        check("t3_accepts", 32'(n_acc), 32'd10);
        check("t3_acks", 32'(n_ack), 32'd10);
        check("t3_first_stall_idx", 32'(first_stall), 32'd9);
        check("t3_stall_long", 32'(stall_cyc >= 16 * (NBits - 1)), 32'd1);
        drain("t3_drained");

        // Randomized rounds at assorted divisors, frames checked by the line model.
        for (int r = 0; r < 4; r++) begin
            div = (r == 0) ? 0 : int'($urandom_range(1, 5));
            wb_xfer(1'b1, 32'h8, 32'(div) | 32'hBEEF_0000, rd);
            mon_div = div;
            wb_xfer(1'b0, 32'h8, 32'h0, rd);
            check("rnd_div_read", rd, 32'(div));
            for (int j = 0; j < 10; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wb_xfer(1'b0, 32'h4, 32'h0, rd);
                    check("rnd_status_hi", {rd[31:16], rd[7:3]}, {16'd0, ParBit[7:3]});
                    check("rnd_status_full", 32'(rd[0]), 32'(rd[15:8] == 8'(Depth)));
                    check("rnd_status_empty", 32'(rd[1]), 32'(rd[15:8] == 8'd0));
                end
                wb_xfer(1'b1, 32'h0, $urandom, rd);
                repeat ($urandom_range(0, (div + 1) * NBits)) @(negedge clk);
            end
            drain("rnd_drained");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
